// File: rtl/alu_resp_checker_pkg.sv
// Shared definitions for the ALU checker slice: opcode map, widths, FSM states.
// Takes over the role of the former alu_defs.vh include.
package alu_resp_checker_pkg;

   localparam int unsigned DW_DEF   = 8;
   localparam int unsigned OPW_DEF  = 3;
   localparam int unsigned CNTW_DEF = 16;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/alu_resp_checker_if.sv
// Sample stream taken at the ALU boundary: {opcode, a, b, y} with valid/ready.
interface alu_resp_checker_if
   import alu_resp_checker_pkg::*;
#(
   parameter int unsigned DW  = DW_DEF,
   parameter int unsigned OPW = OPW_DEF
) ();

   logic           in_valid;
   logic           in_ready;
   logic [OPW-1:0] opcode;
   logic [DW-1:0]  a;
   logic [DW-1:0]  b;
   logic [DW-1:0]  y;

   modport master (output in_valid, opcode, a, b, y, input in_ready);
   modport slave  (input in_valid, opcode, a, b, y, output in_ready);

endinterface

// File: rtl/alu_resp_checker_alu_ref.sv
// Combinational golden ALU model: {opcode, a, b} -> expected result, mod 2^DW.
module alu_ref
   import alu_resp_checker_pkg::*;
#(
   parameter int unsigned DW  = DW_DEF,
   parameter int unsigned OPW = OPW_DEF
) (
   input  logic [OPW-1:0] opcode,
   input  logic [DW-1:0]  a,
   input  logic [DW-1:0]  b,
   output logic [DW-1:0]  y_exp
);

   // Opcode decode; all arithmetic wraps at DW bits, shifts are logical.
   always_comb begin
      y_exp = '0;
      case (op_e'(opcode))
         OP_ADD:  y_exp = a + b;
         OP_SUB:  y_exp = a - b;
         OP_AND:  y_exp = a & b;
         OP_OR:   y_exp = a | b;
         OP_XOR:  y_exp = a ^ b;
         OP_NOT:  y_exp = ~a;
         OP_SHL:  y_exp = a << 1;
         OP_SHR:  y_exp = a >> 1;
         default: y_exp = '0;
      endcase
   end

endmodule

// File: rtl/alu_resp_checker.sv
// ALU response checker: scores each accepted sample against alu_ref through a
// 2-stage pipeline, counts vectors/errors and captures the first failing sample.
module alu_resp_checker
   import alu_resp_checker_pkg::*;
#(
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned OPW  = OPW_DEF,
   parameter int unsigned CNTW = CNTW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [CNTW-1:0]     num_vec,
   alu_resp_checker_if.slave   smp_if,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [CNTW-1:0]     vec_cnt,
   output logic [CNTW-1:0]     err_cnt,
   output logic [OPW-1:0]      fail_op,
   output logic [DW-1:0]       fail_a,
   output logic [DW-1:0]       fail_b,
   output logic [DW-1:0]       fail_y,
   output logic [DW-1:0]       fail_exp
);

   state_e          r_state, w_state_nxt;
   logic            r_drain_cnt;
   logic [CNTW-1:0] r_num_vec;
   logic [CNTW-1:0] r_vec_cnt;
   logic [CNTW-1:0] r_err_cnt;
   logic [CNTW-1:0] w_vec_nxt;
   logic            w_in_ready;
   logic            w_accept;
   logic            w_start_ok;

   logic            r_s1_vld, r_s2_vld, r_s2_mis;
   logic [OPW-1:0]  r_s1_op, r_s2_op;
   logic [DW-1:0]   r_s1_a, r_s1_b, r_s1_y;
   logic [DW-1:0]   r_s2_a, r_s2_b, r_s2_y, r_s2_exp;
   logic [DW-1:0]   w_exp;

   logic [OPW-1:0]  r_fail_op;
   logic [DW-1:0]   r_fail_a, r_fail_b, r_fail_y, r_fail_exp;

   // Ready only while the run still owes samples, so vec_cnt cannot pass num_vec.
   assign w_in_ready      = (r_state == RUN) && (r_vec_cnt != r_num_vec);
   assign w_accept        = smp_if.in_valid & w_in_ready;
   assign w_vec_nxt       = r_vec_cnt + CNTW'(1);
   assign w_start_ok      = start && ((r_state == IDLE) || (r_state == DONE));
   assign smp_if.in_ready = w_in_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and status decode.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE:  if (start) w_state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if ((r_num_vec == '0) || (w_accept && (w_vec_nxt == r_num_vec)))
               w_state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (r_drain_cnt) w_state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) w_state_nxt = RUN;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Two-cycle DRAIN timer: the last sample reaches err_cnt as DONE is entered.
   always_ff @(posedge clk) begin
      if (!rst_n) r_drain_cnt <= 1'b0;
      else        r_drain_cnt <= (r_state == DRAIN) ? ~r_drain_cnt : 1'b0;
   end

   // S1: register the accepted sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_s1_op  <= '0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s1_y   <= '0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_op <= smp_if.opcode;
            r_s1_a  <= smp_if.a;
            r_s1_b  <= smp_if.b;
            r_s1_y  <= smp_if.y;
         end
      end
   end

   alu_ref #(.DW(DW), .OPW(OPW)) u_alu_ref (
      .opcode (r_s1_op),
      .a      (r_s1_a),
      .b      (r_s1_b),
      .y_exp  (w_exp)
   );

   // S2: register expected result and the mismatch verdict.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s2_vld <= 1'b0;
         r_s2_mis <= 1'b0;
         r_s2_op  <= '0;
         r_s2_a   <= '0;
         r_s2_b   <= '0;
         r_s2_y   <= '0;
         r_s2_exp <= '0;
      end else begin
         r_s2_vld <= r_s1_vld;
         r_s2_mis <= r_s1_vld && (w_exp != r_s1_y);
         r_s2_op  <= r_s1_op;
         r_s2_a   <= r_s1_a;
         r_s2_b   <= r_s1_b;
         r_s2_y   <= r_s1_y;
         r_s2_exp <= w_exp;
      end
   end

   // Run counters and first-fail capture; start clears them for a fresh run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_num_vec  <= '0;
         r_vec_cnt  <= '0;
         r_err_cnt  <= '0;
         r_fail_op  <= '0;
         r_fail_a   <= '0;
         r_fail_b   <= '0;
         r_fail_y   <= '0;
         r_fail_exp <= '0;
      end else if (w_start_ok) begin
         r_num_vec  <= num_vec;
         r_vec_cnt  <= '0;
         r_err_cnt  <= '0;
         r_fail_op  <= '0;
         r_fail_a   <= '0;
         r_fail_b   <= '0;
         r_fail_y   <= '0;
         r_fail_exp <= '0;
      end else begin
         if (w_accept) r_vec_cnt <= w_vec_nxt;
         if (r_s2_vld && r_s2_mis) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNTW'(1);
            if (r_err_cnt == '0) begin
               r_fail_op  <= r_s2_op;
               r_fail_a   <= r_s2_a;
               r_fail_b   <= r_s2_b;
               r_fail_y   <= r_s2_y;
               r_fail_exp <= r_s2_exp;
            end
         end
      end
   end

   assign pass     = (r_state == DONE) && (r_err_cnt == '0);
   assign vec_cnt  = r_vec_cnt;
   assign err_cnt  = r_err_cnt;
   assign fail_op  = r_fail_op;
   assign fail_a   = r_fail_a;
   assign fail_b   = r_fail_b;
   assign fail_y   = r_fail_y;
   assign fail_exp = r_fail_exp;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Scoreboard bench for alu_resp_checker: directed vectors with hand-computed
// expected ALU results; per-sample err_cnt and per-run results checked by monitors.
module tb_alu_resp_checker;

   localparam int unsigned DW   = 8;
   localparam int unsigned OPW  = 3;
   localparam int unsigned CNTW = 16;

   typedef struct {
      logic [15:0] vec;
      logic [15:0] err;
      logic        pass;
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  y;
      logic [7:0]  x;
   } run_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [CNTW-1:0] num_vec;
   logic            busy, done, pass;
   logic [CNTW-1:0] vec_cnt, err_cnt;
   logic [OPW-1:0]  fail_op;
   logic [DW-1:0]   fail_a, fail_b, fail_y, fail_exp;

   alu_resp_checker_if #(.DW(DW), .OPW(OPW)) smp ();

   alu_resp_checker #(.DW(DW), .OPW(OPW), .CNTW(CNTW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .num_vec  (num_vec),
      .smp_if   (smp),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .vec_cnt  (vec_cnt),
      .err_cnt  (err_cnt),
      .fail_op  (fail_op),
      .fail_a   (fail_a),
      .fail_b   (fail_b),
      .fail_y   (fail_y),
      .fail_exp (fail_exp)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_miss = 0;
   int          exp_err;
   int          cyc;
   run_t        rq[$];
   logic [15:0] sq[$];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endfunction

   function automatic run_t mk(input logic [15:0] v, input logic [15:0] e, input logic p,
                               input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] y, input logic [7:0] x);
      run_t r;
      r.vec = v; r.err = e; r.pass = p; r.op = op; r.a = a; r.b = b; r.y = y; r.x = x;
      return r;
   endfunction

   task automatic run_start(input logic [15:0] n, input run_t r);
      @(negedge clk);
      start   = 1'b1;
      num_vec = n;
      rq.push_back(r);
      exp_err = 0;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // Drive one sample; x is the hand-computed correct result for (op, a, b).
   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] y, input logic [7:0] x);
      int k;
      k = 0;
      @(negedge clk);
      while (!smp.in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!smp.in_ready) begin
         n_chk++;
         n_miss++;
         $display("FAIL send_ready: got in_ready=0 want 1 within 20 cycles");
         smp.in_valid = 1'b0;
      end else begin
         smp.in_valid = 1'b1;
         smp.opcode   = op;
         smp.a        = a;
         smp.b        = b;
         smp.y        = y;
         if (y !== x) exp_err++;
         sq.push_back(16'(exp_err));
      end
   endtask

   task automatic idle();
      @(negedge clk);
      smp.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int c);
      c = 0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (done) begin
            c = k;
            break;
         end
      end
      if (c == 0) begin
         n_chk++;
         n_miss++;
         $display("FAIL done_timeout: got done=0 want 1 within 50 cycles");
      end
   endtask

   // Accept tracker: a sample accepted at edge t must show in err_cnt after edge t+2.
   logic        d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
   logic        prev_done = 1'b0;
   logic [15:0] sb_e;
   run_t        sb_r;

   always @(posedge clk) begin
      if (!rst_n) begin
         d1 <= 1'b0;
         d2 <= 1'b0;
         d3 <= 1'b0;
         sq.delete();
         rq.delete();
      end else begin
         d1 <= smp.in_valid && smp.in_ready;
         d2 <= d1;
         d3 <= d2;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (d3) begin
            if (sq.size() == 0) begin
               n_chk++;
               n_miss++;
               $display("FAIL sample_sb: got accepted sample want none expected");
            end else begin
               sb_e = sq.pop_front();
               chk("err_cnt_t2", err_cnt, sb_e);
            end
         end
         if (done && !prev_done) begin
            if (rq.size() == 0) begin
               n_chk++;
               n_miss++;
               $display("FAIL run_sb: got done want no run pending");
            end else begin
               sb_r = rq.pop_front();
               chk("run_vec_cnt",  vec_cnt,  sb_r.vec);
               chk("run_err_cnt",  err_cnt,  sb_r.err);
               chk("run_pass",     pass,     sb_r.pass);
               chk("run_fail_op",  fail_op,  sb_r.op);
               chk("run_fail_a",   fail_a,   sb_r.a);
               chk("run_fail_b",   fail_b,   sb_r.b);
               chk("run_fail_y",   fail_y,   sb_r.y);
               chk("run_fail_exp", fail_exp, sb_r.x);
               chk("run_busy",     busy,     0);
            end
         end
      end
      prev_done <= done;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      num_vec      = '0;
      exp_err      = 0;
      smp.in_valid = 1'b0;
      smp.opcode   = '0;
      smp.a        = '0;
      smp.b        = '0;
      smp.y        = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", smp.in_ready, 0);
      chk("rst_busy",     busy,     0);
      chk("rst_done",     done,     0);
      chk("rst_pass",     pass,     0);
      chk("rst_vec_cnt",  vec_cnt,  0);
      chk("rst_err_cnt",  err_cnt,  0);
      chk("rst_fail_op",  fail_op,  0);
      chk("rst_fail_a",   fail_a,   0);
      chk("rst_fail_b",   fail_b,   0);
      chk("rst_fail_y",   fail_y,   0);
      chk("rst_fail_exp", fail_exp, 0);
      rst_n = 1'b1;

      // Five correct samples, back to back
      run_start(5, mk(5, 0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00));
      send(3'd0, 8'h10, 8'h22, 8'h32, 8'h32);
      send(3'd3, 8'h0F, 8'hF0, 8'hFF, 8'hFF);
      send(3'd5, 8'h3C, 8'h00, 8'hC3, 8'hC3);
      send(3'd7, 8'h81, 8'h00, 8'h40, 8'h40);
      send(3'd2, 8'hCC, 8'hAA, 8'h88, 8'h88);
      idle();
      wait_done(cyc);

      // Two wrong samples; first failure captured
      run_start(3, mk(3, 2, 1'b0, 3'd1, 8'h05, 8'h07, 8'h00, 8'hFE));
      send(3'd2, 8'hF0, 8'h3C, 8'h30, 8'h30);
      send(3'd1, 8'h05, 8'h07, 8'h00, 8'hFE);
      send(3'd4, 8'hAA, 8'h55, 8'h00, 8'hFF);
      idle();
      wait_done(cyc);

      // Wrap-around cases
      run_start(4, mk(4, 0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00));
      send(3'd0, 8'hFF, 8'h01, 8'h00, 8'h00);
      send(3'd6, 8'h80, 8'h00, 8'h00, 8'h00);
      send(3'd1, 8'h00, 8'h01, 8'hFF, 8'hFF);
      send(3'd7, 8'h01, 8'h00, 8'h00, 8'h00);
      idle();
      wait_done(cyc);

      // Empty run: RUN one cycle, DRAIN two, then DONE
      run_start(0, mk(0, 0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00));
      chk("zero_in_ready", smp.in_ready, 0);
      wait_done(cyc);
      chk("zero_run_latency", cyc, 3);

      // start while busy is ignored
      run_start(2, mk(2, 0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00));
      send(3'd4, 8'h0F, 8'h33, 8'h3C, 8'h3C);
      @(negedge clk);
      smp.in_valid = 1'b0;
      start        = 1'b1;
      num_vec      = 16'd7;
      @(negedge clk);
      start        = 1'b0;
      chk("busy_start_vec_cnt", vec_cnt, 1);
      chk("busy_start_busy",    busy,    1);
      send(3'd6, 8'h41, 8'h00, 8'h82, 8'h82);
      idle();
      wait_done(cyc);

      // Reset mid-run with a bad sample in flight
      run_start(4, mk(4, 0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00));
      send(3'd4, 8'h12, 8'h34, 8'h26, 8'h26);
      send(3'd6, 8'h41, 8'h00, 8'h00, 8'h82);
      @(negedge clk);
      smp.in_valid = 1'b0;
      rst_n        = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_busy",    busy,    0);
      chk("abort_vec_cnt", vec_cnt, 0);
      chk("abort_err_cnt", err_cnt, 0);
      chk("abort_fail_y",  fail_y,  0);
      run_start(1, mk(1, 0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00));
      send(3'd0, 8'h01, 8'h02, 8'h03, 8'h03);
      idle();
      wait_done(cyc);

      repeat (4) @(negedge clk);
      chk("sample_sb_empty", sq.size(), 0);
      chk("run_sb_empty",    rq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
      $finish;
   end

endmodule
